// File: rtl/echo_trail_gen_if.sv
// -----------------------------------------------------------------------------
// echo_trail_gen_if
// Bundles the frame/pixel inputs and the echo outputs of echo_trail_gen.
//   master : drives frame_start, pixel_valid, half_x_dist, inst_intensity,
//            feedback, rate, wet; observes intensity, intensity_valid,
//            update_busy, overrun_count.
//   slave  : the echo_trail_gen side (mirror of master).
// Parameter INSTRUMENT_COUNT sets the number of packed 8-bit channel lanes.
// -----------------------------------------------------------------------------
interface echo_trail_gen_if #(
    parameter int INSTRUMENT_COUNT = 3
);
    logic                              frame_start;
    logic                              pixel_valid;
    logic [INSTRUMENT_COUNT-1:0][7:0]  half_x_dist;
    logic [INSTRUMENT_COUNT-1:0][7:0]  inst_intensity;
    logic [9:0]                        feedback;
    logic [9:0]                        rate;
    logic [9:0]                        wet;
    logic [7:0]                        intensity;
    logic                              intensity_valid;
    logic                              update_busy;
    logic [7:0]                        overrun_count;

    modport master (
        output frame_start, pixel_valid, half_x_dist, inst_intensity,
               feedback, rate, wet,
        input  intensity, intensity_valid, update_busy, overrun_count
    );

    modport slave (
        input  frame_start, pixel_valid, half_x_dist, inst_intensity,
               feedback, rate, wet,
        output intensity, intensity_valid, update_busy, overrun_count
    );
endinterface

// File: rtl/echo_trail_gen.sv
// -----------------------------------------------------------------------------
// echo_trail_gen
// Per-channel echo history with feedback decay, updated once per frame, and a
// 4-stage pixel path that looks up the echo tap chosen by each channel's shape
// distance and the delay rate, sums channels with saturation and applies wet
// gain.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : echo_trail_gen_if.slave
//          in : frame_start, pixel_valid, half_x_dist[N], inst_intensity[N],
//               feedback, rate, wet (10-bit pots, top 8 bits used)
//          out: intensity, intensity_valid, update_busy, overrun_count
//
// Optional feature macro: ECHO_TRAIL_OVERRUN_CNT_EN
//   defined   -> overrun_count counts (saturating) frame_start pulses that
//                arrive while update_busy is high
//   undefined -> overrun_count is tied to zero
// -----------------------------------------------------------------------------
module echo_trail_gen #(
    parameter int INSTRUMENT_COUNT = 3,
    parameter int DEPTH            = 64
) (
    input  logic            clk,
    input  logic            rst,
    echo_trail_gen_if.slave bus
);
    localparam int PIPE_LATENCY = 4;
    localparam int AW           = $clog2(DEPTH);
    localparam int SUM_W        = 8 + $clog2(INSTRUMENT_COUNT);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_WRITE0
    } state_t;

    state_t                            state_q;
    logic [AW-1:0]                     idx_q;
    logic                              busy_q;
    logic [7:0]                        fb_s_q;
    logic [7:0]                        rate_s_q;
    logic [7:0]                        wet_s_q;
    logic [INSTRUMENT_COUNT-1:0][7:0]  new_sample_q;

    // -------------------------------------------------------------------------
    // History update FSM. Shadow pot values are taken only in LATCH so that a
    // whole frame is rendered and decayed with one consistent setting.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CLEAR;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            fb_s_q       <= '0;
            rate_s_q     <= '0;
            wet_s_q      <= '0;
            new_sample_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    idx_q <= idx_q + AW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        state_q <= ST_LATCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    fb_s_q   <= bus.feedback[9:2];
                    rate_s_q <= bus.rate[9:2];
                    wet_s_q  <= bus.wet[9:2];
                    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                        new_sample_q[i] <= bus.inst_intensity[i][7]
                                           ? {bus.inst_intensity[i][6:0], 1'b0}
                                           : 8'h00;
                    end
                    idx_q   <= IDX_LAST;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Walk downwards so hist[idx-1] is still the old value.
                    idx_q <= idx_q - AW'(1);
                    if (idx_q == AW'(1)) begin
                        state_q <= ST_WRITE0;
                    end
                end
                ST_WRITE0: begin
                    // idx_q has reached 0 here; the write path uses it.
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    logic mem_we;
    assign mem_we = (state_q == ST_CLEAR) || (state_q == ST_SHIFT) ||
                    (state_q == ST_WRITE0);

    logic [INSTRUMENT_COUNT-1:0]       hv_vec;
    logic [INSTRUMENT_COUNT-1:0][7:0]  smp_vec;

    // -------------------------------------------------------------------------
    // Per-channel history RAM plus pixel stages S1 (offset) and S2 (tap read).
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < INSTRUMENT_COUNT; gi++) begin : g_chan
            logic [7:0]  hist_mem [DEPTH];
            logic [7:0]  prev_rd;
            logic [15:0] decay_prod;
            logic [7:0]  wr_data_d;
            logic [15:0] off_q;
            logic        nz_q;
            logic [7:0]  smp_q;
            logic        hv_q;
            logic        hv_d;
            logic [7:0]  tap_rd;
            logic        unused_lo;

            assign prev_rd    = hist_mem[idx_q - AW'(1)];
            assign decay_prod = 16'(prev_rd) * 16'(fb_s_q);

            always_comb begin
                wr_data_d = 8'h00;
                case (state_q)
                    ST_SHIFT:  wr_data_d = decay_prod[15:8];
                    ST_WRITE0: wr_data_d = new_sample_q[gi];
                    default:   wr_data_d = 8'h00;
                endcase
            end

            always_ff @(posedge clk) begin
                if (mem_we) begin
                    hist_mem[idx_q] <= wr_data_d;
                end
            end

            // Taps beyond the history length, and lookups during an update,
            // contribute nothing.
            assign hv_d   = nz_q && (int'(off_q[15:8]) < DEPTH) && !busy_q;
            assign tap_rd = hist_mem[off_q[8+AW-1:8]];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    off_q <= '0;
                    nz_q  <= 1'b0;
                    smp_q <= '0;
                    hv_q  <= 1'b0;
                end else begin
                    off_q <= 16'(bus.half_x_dist[gi]) * 16'(rate_s_q);
                    nz_q  <= (bus.half_x_dist[gi] != 8'h00);
                    smp_q <= tap_rd;
                    hv_q  <= hv_d;
                end
            end

            assign hv_vec[gi]  = hv_q;
            assign smp_vec[gi] = smp_q;
            assign unused_lo   = ^{off_q[7:0], decay_prod[7:0]};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // S3: saturating channel sum.  S4: wet gain (truncating).
    // -------------------------------------------------------------------------
    logic [SUM_W-1:0]            sum_d;
    logic [7:0]                  sat_d;
    logic [7:0]                  sat_q;
    logic [15:0]                 wet_prod_d;
    logic [7:0]                  intensity_q;
    logic [PIPE_LATENCY-1:0]     valid_pipe_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
            if (hv_vec[i]) begin
                sum_d = sum_d + SUM_W'(smp_vec[i]);
            end
        end
        sat_d = (sum_d > SUM_W'(255)) ? 8'hFF : sum_d[7:0];
    end

    assign wet_prod_d = 16'(sat_q) * 16'(wet_s_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q        <= '0;
            intensity_q  <= '0;
            valid_pipe_q <= '0;
        end else begin
            sat_q        <= sat_d;
            intensity_q  <= wet_prod_d[15:8];
            valid_pipe_q <= {valid_pipe_q[PIPE_LATENCY-2:0], bus.pixel_valid};
        end
    end

    assign bus.intensity       = intensity_q;
    assign bus.intensity_valid = valid_pipe_q[PIPE_LATENCY-1];
    assign bus.update_busy     = busy_q;

`ifdef ECHO_TRAIL_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= '0;
        end else if (bus.frame_start && busy_q && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign bus.overrun_count = overrun_q;
`else
    assign bus.overrun_count = 8'h00;
`endif

    logic unused_top;
    assign unused_top = ^{bus.feedback[1:0], bus.rate[1:0], bus.wet[1:0],
                          wet_prod_d[7:0]};
endmodule

// File: tb/tb_echo_trail_gen.sv
`timescale 1ns/1ps
module tb_echo_trail_gen;
    localparam int NCH = 3;
    localparam int DEP = 64;

`ifdef ECHO_TRAIL_OVERRUN_CNT_EN
    localparam int OVR_EXP = 1;
`else
    localparam int OVR_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    echo_trail_gen_if #(.INSTRUMENT_COUNT(NCH)) bus();

    echo_trail_gen #(.INSTRUMENT_COUNT(NCH), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: history as plain arrays, pots as captured per frame.
    int hist_m [NCH][DEP];
    int rate_m = 0;
    int wet_m  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < DEP; k++)
                hist_m[c][k] = 0;
        rate_m = 0;
        wet_m  = 0;
    endfunction

    function automatic void model_frame();
        int fb;
        int smp;
        fb = int'(bus.feedback[9:2]);
        for (int c = 0; c < NCH; c++) begin
            smp = bus.inst_intensity[c][7] ? int'(bus.inst_intensity[c][6:0]) * 2 : 0;
            for (int k = DEP - 1; k >= 1; k--)
                hist_m[c][k] = (hist_m[c][k-1] * fb) / 256;
            hist_m[c][0] = smp;
        end
        rate_m = int'(bus.rate[9:2]);
        wet_m  = int'(bus.wet[9:2]);
    endfunction

    function automatic int model_query(input logic [NCH-1:0][7:0] d);
        int s;
        int tap;
        s = 0;
        for (int c = 0; c < NCH; c++) begin
            if (d[c] != 8'h00) begin
                tap = (int'(d[c]) * rate_m) / 256;
                if (tap < DEP) s += hist_m[c][tap];
            end
        end
        if (s > 255) s = 255;
        return (s * wet_m) / 256;
    endfunction

    // One frame update; counts busy cycles, optionally fires a second
    // frame_start 'second_at' cycles into the busy window.
    task automatic do_frame(input string tag, input int exp_busy, input int second_at);
        int n;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        n = 0;
        while (bus.update_busy === 1'b1 && n < 1000) begin
            n++;
            bus.frame_start = (n == second_at);
            @(negedge clk);
        end
        bus.frame_start = 1'b0;
        check(tag, 16'(n), 16'(exp_busy));
        model_frame();
    endtask

    // One pixel lookup; checks 4-cycle valid latency and the intensity.
    task automatic query(input string tag, input logic [NCH-1:0][7:0] d, input int exp);
        bus.half_x_dist = d;
        bus.pixel_valid = 1'b1;
        @(negedge clk);
        bus.pixel_valid = 1'b0;
        bus.half_x_dist = '0;
        repeat (2) @(negedge clk);
        check({tag, "_early"}, 16'(bus.intensity_valid), 16'd0);
        @(negedge clk);
        check({tag, "_valid"}, 16'(bus.intensity_valid), 16'd1);
        check(tag, 16'(bus.intensity), 16'(exp));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0][7:0] d;
        int n;

        bus.frame_start    = 1'b0;
        bus.pixel_valid    = 1'b0;
        bus.half_x_dist    = '0;
        bus.inst_intensity = '0;
        bus.feedback       = '0;
        bus.rate           = '0;
        bus.wet            = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_intensity", 16'(bus.intensity), 16'h0);
        check("rst_valid", 16'(bus.intensity_valid), 16'h0);
        check("rst_busy", 16'(bus.update_busy), 16'h1);
        check("rst_overrun", 16'(bus.overrun_count), 16'h0);

        // CLEAR window after release
        rst = 1'b1;
        n = 0;
        while (bus.update_busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("clear_busy", 16'(n), 16'd64);

        for (int q = 0; q < 8; q++) begin
            for (int c = 0; c < NCH; c++) d[c] = 8'($urandom_range(1, 255));
            query("clear_q", d, 0);
        end

        // Single hit
        bus.inst_intensity    = '0;
        bus.inst_intensity[0] = 8'hC0;
        bus.feedback = 10'h3FC;
        bus.wet      = 10'h3FC;
        bus.rate     = 10'h100;
        do_frame("hit_busy", 65, 0);
        d = '0; d[0] = 8'd3;
        query("hit_tap0", d, 8'h7F);
        d = '0; d[0] = 8'd4;
        query("hit_tap1", d, 8'h00);

        // Decay
        bus.inst_intensity = '0;
        bus.feedback = 10'h200;
        do_frame("decay_busy", 65, 0);
        d = '0; d[0] = 8'd4;
        query("decay_tap1", d, 8'h3F);
        d = '0; d[0] = 8'd2;
        query("decay_tap0", d, 8'h00);

        // Saturation across channels
        for (int c = 0; c < NCH; c++) bus.inst_intensity[c] = 8'hC0;
        bus.wet = 10'h3FC;
        do_frame("sat_busy", 65, 0);
        for (int c = 0; c < NCH; c++) d[c] = 8'd1;
        query("sat", d, 8'hFE);

        // Overrun: extra frame_start inside the busy window
        bus.inst_intensity = '0;
        do_frame("ovr_busy", 65, 10);
        check("overrun", 16'(bus.overrun_count), 16'(OVR_EXP));

        // Randomized frames against the model
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < NCH; c++) bus.inst_intensity[c] = 8'($urandom_range(0, 255));
            bus.feedback = 10'($urandom_range(0, 1023));
            bus.rate     = 10'($urandom_range(0, 511));
            bus.wet      = 10'($urandom_range(0, 1023));
            do_frame("rnd_busy", 65, 0);
            for (int q = 0; q < 6; q++) begin
                for (int c = 0; c < NCH; c++)
                    d[c] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                query("rnd_q", d, model_query(d));
            end
        end

        // Reset in the middle of SHIFT
        for (int c = 0; c < NCH; c++) bus.inst_intensity[c] = 8'hFF;
        bus.feedback    = 10'h3FC;
        bus.half_x_dist = {NCH{8'h01}};
        bus.pixel_valid = 1'b1;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_pre_valid", 16'(bus.intensity_valid), 16'h1);
        rst = 1'b0;
        #1;
        check("mid_intensity", 16'(bus.intensity), 16'h0);
        check("mid_valid", 16'(bus.intensity_valid), 16'h0);
        check("mid_busy", 16'(bus.update_busy), 16'h1);
        check("mid_overrun", 16'(bus.overrun_count), 16'h0);
        model_reset();
        @(negedge clk);
        bus.pixel_valid = 1'b0;
        bus.half_x_dist = '0;
        rst = 1'b1;
        n = 0;
        while (bus.update_busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("reclear_busy", 16'(n), 16'd64);

        // Empty frame with rate_q=0xFF so distance d selects tap d-1
        bus.inst_intensity = '0;
        bus.feedback = 10'($urandom_range(0, 1023));
        bus.rate     = 10'h3FC;
        bus.wet      = 10'h3FC;
        do_frame("reclear_frame", 65, 0);
        for (int t = 1; t <= DEP; t++) begin
            for (int c = 0; c < NCH; c++) d[c] = 8'(t);
            query("reclear_tap", d, model_query(d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/echo_trail_gen.md
Name: echo_trail_gen

Overview:
- Parametrised successor of the per-instrument delay visualiser.
- Keeps a per-channel history of hit intensities, updated once per frame, with feedback decay on every shift.
- For each pixel, looks up the echo tap selected by that pixel's shape distance and the delay rate, sums the channels with saturation and applies wet scaling.
- Sits between the shape generators, which supply half_x_dist, and the pixel compositor.

Parameters:
- INSTRUMENT_COUNT, 3, number of instrument channels (1..8).
- DEPTH, 64, history taps per channel; power of two, 8..256.
- PIPE_LATENCY, 4, fixed pixel-path latency in cycles; informational only, must not be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse once per frame, issued in vertical blanking.
- pixel_valid  in  1  qualifies the half_x_dist lookup this cycle.
- half_x_dist  in  8 x INSTRUMENT_COUNT  per-channel shape distance; 0 means outside the shape.
- inst_intensity  in  8 x INSTRUMENT_COUNT  bit 7 is the hit flag, bits 6:0 are the level.
- feedback  in  10  decay pot; fb_q = feedback[9:2].
- rate  in  10  delay-rate pot; rate_q = rate[9:2].
- wet  in  10  output gain pot; wet_q = wet[9:2].
- intensity  out  8  echo intensity for the pixel.
- intensity_valid  out  1  pixel_valid delayed by 4 cycles.
- update_busy  out  1  history clear or update in progress.
- overrun_count  out  8  frame_start pulses dropped while busy (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous): intensity=0, intensity_valid=0, overrun_count=0, all pipeline registers 0, update_busy=1, FSM=CLEAR with idx=0.
- History storage: one DEPTH x 8 distributed RAM per channel, combinational read. All channels step in lockstep and share the FSM.
- CLEAR:
  - Writes 0 to entry idx, idx increments each cycle.
  - After DEPTH cycles, go to IDLE and drop update_busy.
  - Any frame_start during CLEAR is ignored.
- IDLE: update_busy=0. On frame_start, go to LATCH and set update_busy=1 in the next cycle.
- LATCH (1 cycle):
  - Capture fb_q, rate_q and wet_q into shadow registers. These are the only values used until the next LATCH.
  - Capture new_sample[i] = hit ? {level, 1'b0} : 0.
  - Set idx = DEPTH-1.
- SHIFT (DEPTH-1 cycles):
  - hist[idx] <= (hist[idx-1] * fb_q) >> 8, then idx decrements.
  - Descending order so no entry is read after being overwritten.
- WRITE0 (1 cycle): hist[0] <= new_sample, then go to IDLE.
- Busy window: update_busy is high for exactly DEPTH+1 cycles per update.
- frame_start while update_busy=1: ignored and no FSM change; counted only with the optional feature.
- Pixel pipeline, 4 cycles, all channels in parallel:
  - S1: off[i] = half_x_dist[i] * rate_q (16 bits).
  - S2: tap[i] = off[i][15:8]. hv[i] = (half_x_dist[i] != 0) && tap[i] < DEPTH && !update_busy. Read hist[tap].
  - S3: sum = sum of (hv ? sample : 0), width 8+clog2(INSTRUMENT_COUNT), saturated to 8'hFF.
  - S4: intensity = (sum * wet_q) >> 8.
- intensity_valid follows pixel_valid with a 4-cycle delay. intensity is computed every cycle regardless of pixel_valid.
- Boundaries:
  - tap >= DEPTH contributes 0.
  - fb_q=0: every tap except 0 is cleared after one update.
  - wet_q=0xFF maps 0xFF to 0xFE; no rounding.
- Reset mid-update: state is abandoned, CLEAR restarts on rst release, and partial history is discarded.

Optional Feature:
- Macro: ECHO_TRAIL_OVERRUN_CNT_EN.
- Defined: overrun_count increments, saturating at 8'hFF, on each frame_start seen while update_busy=1. Cleared only by reset.
- Not defined: overrun_count is tied to 8'h00 and no counter logic is built. Port list is unchanged.

Test Plan:
- Reset release, INSTRUMENT_COUNT=3, DEPTH=64 -> update_busy high for exactly 64 cycles. Afterwards, queries with half_x_dist=1..255 return intensity 0.
- Single hit:
  - Stimulus: inst_intensity[0]=8'hC0, feedback=wet=10'h3FC, rate=10'h100 (rate_q=0x40), one frame_start.
  - Busy: update_busy high for 65 cycles.
  - half_x_dist[0]=3 -> intensity 0x7F, intensity_valid exactly 4 cycles after pixel_valid.
  - half_x_dist[0]=4 -> intensity 0.
- Decay:
  - Stimulus: after the single-hit frame, set feedback=10'h200 (fb_q=0x80), no hit, frame_start.
  - half_x_dist[0]=4 (tap 1) -> intensity (0x40*0xFF)>>8 = 0x3F.
  - half_x_dist[0]=2 (tap 0) -> intensity 0.
- Saturation: all three channels hit with 8'hC0, wet_q=0xFF, all half_x_dist=1 -> sum 0x180 clipped to 0xFF, intensity 0xFE.
- Overrun: second frame_start 10 cycles after the first -> update_busy duration unchanged at 65 cycles. overrun_count=1 with the macro defined, 0 without.
- Reset mid-SHIFT: rst low at cycle 20 of an update -> intensity and intensity_valid go to 0 immediately. On release, 64-cycle CLEAR, then all taps read 0.
